// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and the display mux that consumes its digits.
package bin2bcd_seq_pkg;

  localparam int W      = 9;
  localparam int DIGITS = 3;

  // Display-mux codes outside the 0..9 digit range
  localparam logic [3:0] BCD_MINUS = 4'd10;
  localparam logic [3:0] BCD_BLANK = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble corrector: adds 3 when the BCD nibble is 5 or more.
// Latency: combinational. Backpressure: none, pure function.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sign/magnitude recovery of the 9-bit adder result plus iterative double-dabble into 3 BCD digits.
// Latency: 10 cycles from the accepting edge to the done pulse; one result per 11 cycles back-to-back.
// Backpressure: start is ignored while busy (no queueing); outputs hold until the next done.
import bin2bcd_seq_pkg::*;

module bin2bcd_seq #(
  parameter int W      = bin2bcd_seq_pkg::W,
  parameter int DIGITS = bin2bcd_seq_pkg::DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic         neg,
  output logic [3:0]   bcd0,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd2
);

  localparam int SCR_W = 4*DIGITS + W;
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  state_t           state;
  logic [3:0]       cnt;
  logic [SCR_W-1:0] scr;
  logic [SCR_W-1:0] scr_adj;
  logic             neg_pend;
  logic             neg_in;
  logic [W-1:0]     mag;
  logic [W-1:0]     low_ext;

  // In subtract mode a clear carry means the true result is low - 256
  assign low_ext = {1'b0, bin[W-2:0]};
  assign neg_in  = sub & ~bin[W-1];
  assign mag     = !sub ? bin : (bin[W-1] ? low_ext : HALF - low_ext);

  assign scr_adj[W-1:0] = scr[W-1:0];
  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scr[W+4*d +: 4]),
      .dout (scr_adj[W+4*d +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      scr      <= '0;
      neg_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      neg      <= 1'b0;
      bcd0     <= 4'd0;
      bcd1     <= 4'd0;
      bcd2     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scr      <= {{(4*DIGITS){1'b0}}, mag};
            neg_pend <= neg_in;
            cnt      <= 4'd0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= {scr_adj[SCR_W-2:0], 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'(W-1)) state <= DONE;
        end
        DONE: begin
          bcd0  <= scr[W +: 4];
          bcd1  <= scr[W+4 +: 4];
          bcd2  <= scr[W+8 +: 4];
          neg   <= neg_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed handshake/reset cases plus a randomized-order
// exhaustive sweep and random conversions, all against an arithmetic reference.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] bin = 9'd0;
  logic       sub = 1'b0;
  logic       busy, done, neg;
  logic [3:0] bcd0, bcd1, bcd2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .neg   (neg),
    .bcd0  (bcd0),
    .bcd1  (bcd1),
    .bcd2  (bcd2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret {Cout,S} as a signed result, then split into decimal digits
  function automatic logic [12:0] model(input logic [8:0] b, input logic s);
    int v, m;
    if (!s)        v = int'(b);
    else if (b[8]) v = int'(b[7:0]);
    else           v = int'(b[7:0]) - 256;
    m = (v < 0) ? -v : v;
    return {v < 0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [12:0] observed();
    return {neg, bcd2, bcd1, bcd0};
  endfunction

  task automatic convert(input logic [8:0] b, input logic s, input string tag);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; bin = b; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    bin = 9'($urandom);
    sub = 1'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 10);
    check({tag, "_val"}, observed(), model(b, s));
    check({tag, "_busy_end"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at[$];
    int ndone;
    int off, k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {busy, done, observed()}, 15'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outs", {busy, done, observed()}, 15'd0);

    convert(9'h1FE, 1'b0, "add510");
    check("add510_digits", observed(), {1'b0, 4'd5, 4'd1, 4'd0});
    convert(9'h0F6, 1'b1, "sub_m10");
    check("sub_m10_digits", observed(), {1'b1, 4'd0, 4'd1, 4'd0});
    convert(9'h001, 1'b1, "sub_m255");
    check("sub_m255_digits", observed(), {1'b1, 4'd2, 4'd5, 4'd5});
    convert(9'h100, 1'b1, "sub_zero");
    check("sub_zero_digits", observed(), {1'b0, 4'd0, 4'd0, 4'd0});
    convert(9'h000, 1'b1, "sub_m256");
    check("sub_m256_digits", observed(), {1'b1, 4'd2, 4'd5, 4'd6});

    // start held high through a whole conversion and into the done cycle
    @(posedge clk); #1;
    start = 1'b1; bin = 9'd127; sub = 1'b0;
    @(posedge clk); #1;
    bin = 9'h0FF;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == 11) start = 1'b0;
      if (done) begin
        done_at.push_back(c);
        if (done_at.size() == 1) check("hold_first_val", observed(), {1'b0, 4'd1, 4'd2, 4'd7});
        else check("hold_second_val", observed(), {1'b0, 4'd2, 4'd5, 4'd5});
      end
    end
    check("hold_ndone", done_at.size(), 2);
    check("hold_first_at", (done_at.size() > 0) ? done_at[0] : -1, 10);
    check("hold_second_at", (done_at.size() > 1) ? done_at[1] : -1, 21);

    // reset in the middle of a conversion
    convert(9'd300, 1'b0, "c300");
    @(posedge clk); #1;
    start = 1'b1; bin = 9'd45; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outs", {busy, done, observed()}, 15'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle_outs", {busy, observed()}, 14'd0);
    convert(9'd45, 1'b0, "after_abort");
    check("after_abort_digits", observed(), {1'b0, 4'd0, 4'd4, 4'd5});

    // every {sub, bin} combination, visited from a random starting point
    off = int'($urandom_range(0, 1023));
    for (int i = 0; i < 1024; i++) begin
      k = (i + off) % 1024;
      convert(9'(k), 1'(k >> 9), "sweep");
    end

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      convert(9'($urandom), 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits between the 8-bit adder/subtractor and the 7-segment display multiplexer. It takes the raw 9-bit adder result {Cout, S} and the add/subtract mode, recovers sign and magnitude, and converts the magnitude to three BCD digits with an iterative shift-add-3 (double-dabble) engine. A start/busy/done handshake frames each conversion. The registered digits and sign feed the digit-select mux, which can then show a minus sign instead of a blank.

## Interface
Parameters:
- W, 9, binary magnitude width; equals the number of shift iterations.
- DIGITS, 3, number of BCD output digits.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a conversion; sampled only in IDLE.
- bin  in  9  raw adder result {Cout, S}.
- sub  in  1  1 = subtraction result, 0 = addition result.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; outputs were updated on this edge.
- neg  out  1  result is negative.
- bcd0  out  4  units digit.
- bcd1  out  4  tens digit.
- bcd2  out  4  hundreds digit.

## Operation
- States: IDLE, SHIFT, DONE.
- Sign and magnitude are computed from bin/sub only on the accepting edge.
  - sub=0: neg=0, mag=bin, range 0..510.
  - sub=1, bin[8]=1: neg=0, mag={0,bin[7:0]}.
  - sub=1, bin[8]=0: neg=1, mag=9'h100 - {0,bin[7:0]}, range 1..256.
- IDLE with start=1:
  - Load the scratch register as {12'b0, mag}.
  - Latch the pending sign, clear the iteration counter, go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble of the scratch register that is ≥5.
  - Shift the whole 21-bit register left by 1.
  - Increment the counter.
  - After the W-th iteration, go to DONE.
- DONE:
  - Copy the scratch nibbles to bcd2/bcd1/bcd0 and the pending sign to neg.
  - Pulse done, go to IDLE.
- bcd*/neg hold their values between conversions and change only on a DONE edge.
- start while busy is ignored, with no queueing.
- bin/sub changes after the accepting edge have no effect.
- The maximum magnitude, 510, fits in 3 digits; no overflow handling is needed.

## Timing
- Reset value of every output is 0, including busy, done, neg and all digits. State returns to IDLE.
- Reset mid-conversion aborts the conversion. No done pulse is produced, and the outputs are cleared.
- Cycle-level sequence, with start accepted at edge E0:
  - busy=1 after E0.
  - Iterations run on edges E0+1 … E0+9.
  - State is DONE after E0+9.
  - On edge E0+10: outputs update, done=1, busy=0.
  - Total latency is 10 cycles.
- done is high for exactly one cycle.
- start may be asserted in the done cycle. It is accepted at E0+11, so back-to-back throughput is one result per 11 cycles.
- start and rst high together: rst wins.

## Structure
- Shared package holds:
  - the state enum (IDLE, SHIFT, DONE);
  - constants W=9 and DIGITS=3;
  - BCD_BLANK=4'd11 and BCD_MINUS=4'd10, for the display mux.
- One sub-module, bcd_add3: 4-bit combinational corrector that adds 3 when the input is ≥5. It is instantiated DIGITS times in the SHIFT datapath.
- The counter is 4 bits wide and saturates only through the state transition.

## Test plan
- sub=0, bin=9'h1FE, start pulse → done exactly 10 cycles later; bcd2/1/0=5/1/0, neg=0.
- sub=1, bin=9'h0F6 → 0/1/0, neg=1. Then sub=1, bin=9'h001 → 2/5/5, neg=1.
- sub=1, bin=9'h100 → 0/0/0, neg=0. Then sub=1, bin=9'h000 → 2/5/6, neg=1.
- Start 127 (sub=0); hold start high through busy and change bin to 9'h0FF mid-run → single done with 1/2/7. A second start held into the done cycle is accepted, and 2/5/5 arrives 11 cycles after the first done.
- Complete a conversion of 300, then start 45 and assert rst at E0+5 → all outputs 0, no done pulse. After release, the next start yields 0/4/5.
- Exhaustive sweep of bin (sub=0 and sub=1) against a reference model → digits and neg match for all 1024 cases.
